// File: rtl/cpu_6502_int_ctrl.sv
// 6502-style interrupt controller: synchronises IRQ/NMI inputs, runs the
// post-reset hold sequence and hands one service (RESET/NMI/IRQ) at a time
// to the CPU at opcode-fetch boundaries.

// Per-bit synchroniser; resets to 1 so an inactive-low input reads idle.
module cpu_6502_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  // Shift the raw input through STAGES flops.
  always_ff @(posedge clk or negedge res) begin
    if (!res) sr <= '1;
    else      sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

module cpu_6502_int_ctrl #(
  parameter int N_IRQ        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 7
) (
  input  logic             clk,
  input  logic             res,
  input  logic             rdy,
  input  logic [N_IRQ-1:0] irq_n,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic             nmi_n,
  input  logic             i_flag,
  input  logic             fetch_boundary,
  input  logic             int_ack,
  output logic             int_req,
  output logic [1:0]       int_type,
  output logic [15:0]      vector_addr,
  output logic             cpu_hold,
  output logic [N_IRQ-1:0] irq_pending
);
  localparam int CW = $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_IRQ  = 2'b01;
  localparam logic [1:0] T_NMI  = 2'b10;
  localparam logic [1:0] T_RES  = 2'b11;

  typedef enum logic [1:0] {RST_SEQ, IDLE, SERVICE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [N_IRQ-1:0]  irq_sync;
  logic              nmi_sync;
  logic              nmi_prev;
  logic              nmi_latch;
  logic              nmi_edge;
  logic              nmi_exit;
  logic              irq_active;

  // One synchroniser lane per IRQ source.
  for (genvar g = 0; g < N_IRQ; g++) begin : g_irq
    cpu_6502_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .res (res),
      .d   (irq_n[g]),
      .q   (irq_sync[g])
    );
  end

  cpu_6502_sync_bit #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk (clk),
    .res (res),
    .d   (nmi_n),
    .q   (nmi_sync)
  );

  // Pending is a pure level follower; rdy does not gate it.
  always_ff @(posedge clk or negedge res) begin
    if (!res) irq_pending <= '0;
    else      irq_pending <= ~irq_sync & irq_en;
  end

  assign irq_active = (|irq_pending) & ~i_flag;
  assign nmi_edge   = nmi_prev & ~nmi_sync;
  assign nmi_exit   = rdy & int_ack & (state == SERVICE) & (int_type == T_NMI);

  // NMI edge latch: a new edge wins over the clear at service exit.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      nmi_prev  <= 1'b1;
      nmi_latch <= 1'b0;
    end else begin
      nmi_prev <= nmi_sync;
      if (nmi_edge)      nmi_latch <= 1'b1;
      else if (nmi_exit) nmi_latch <= 1'b0;
    end
  end

  // Sequencing FSM with registered outputs; rdy=0 freezes everything here.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= RST_SEQ;
      cnt         <= '0;
      cpu_hold    <= 1'b1;
      int_req     <= 1'b0;
      int_type    <= T_RES;
      vector_addr <= 16'hFFFC;
    end else if (rdy) begin
      case (state)
        RST_SEQ: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(RESET_CYCLES - 1)) begin
            state    <= SERVICE;
            cpu_hold <= 1'b0;
            int_req  <= 1'b1;
          end
        end
        IDLE: begin
          if (fetch_boundary) begin
            if (nmi_latch) begin
              state       <= SERVICE;
              int_req     <= 1'b1;
              int_type    <= T_NMI;
              vector_addr <= 16'hFFFA;
            end else if (irq_active) begin
              state       <= SERVICE;
              int_req     <= 1'b1;
              int_type    <= T_IRQ;
              vector_addr <= 16'hFFFE;
            end
          end
        end
        SERVICE: begin
          if (int_ack) begin
            state       <= IDLE;
            int_req     <= 1'b0;
            int_type    <= T_NONE;
            vector_addr <= 16'h0000;
          end
        end
        default: begin
          state    <= RST_SEQ;
          cnt      <= '0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end
endmodule
